// File: rtl/serial_subtractor_ctrl_if.sv
// rtl/serial_subtractor_ctrl_if.sv - start/busy/done handshake bundle for the bit-serial subtractor
//
// Purpose: carries operands, the start request and the registered result
// between a requester (master) and serial_subtractor_ctrl (slave).
// Signals:
//   start      master->slave  request, sampled only while the subtractor is idle
//   a, b       master->slave  minuend / subtrahend, WIDTH bits
//   bin_in     master->slave  initial borrow-in
//   busy       slave->master  high while bits are being processed
//   done       slave->master  one-cycle pulse when diff/borrow_out update
//   diff       slave->master  registered (a - b - bin_in) mod 2^WIDTH
//   borrow_out slave->master  registered final borrow
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, bin_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, bin_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial N-bit subtractor around one full-subtractor cell
//
// Purpose: computes a - b - bin_in one bit per clock, LSB first, with an
// IDLE -> RUN -> DONE sequencer. Latency is WIDTH cycles from the accepting
// edge to done; one operation per WIDTH+2 cycles.
// Ports:
//   clk  input  rising-edge clock
//   rst  input  asynchronous active-high reset; discards any operation in flight
//   bus  slave modport of serial_subtractor_ctrl_if (start/a/b/bin_in in,
//        busy/done/diff/borrow_out out, all outputs registered)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor bit cell on the current LSBs and the borrow register.
  logic x_bit, y_bit, d_bit, br_next;
  assign x_bit   = a_q[0];
  assign y_bit   = b_q[0];
  assign d_bit   = x_bit ^ y_bit ^ br_q;
  assign br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        r_d  = {d_bit, r_q[WIDTH-1:1]};
        br_d = br_next;
        if (cnt_q == LAST) begin
          // Final bit: r_d already holds the complete result.
          diff_d   = r_d;
          borrow_d = br_next;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from the state register, so no input reaches an output combinationally.
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - self-checking bench for serial_subtractor_ctrl (WIDTH 8 and 2)
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(8)) if8 ();
  serial_subtractor_ctrl_if #(.WIDTH(2)) if2 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_subtractor_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Reference: plain integer subtraction; bit W is the borrow, low bits the difference.
  function automatic int ref_sub(input int w, input int a, input int b, input int bin);
    int r;
    int m;
    m = (1 << w) - 1;
    r = a - b - bin;
    return ((r < 0) ? (1 << w) : 0) | (r & m);
  endfunction

  // One WIDTH=8 operation; returns the observed result, edges to done (-1 on timeout)
  // and the number of cycles where busy/done disagreed with the expected handshake.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output int lat, output int hs_bad);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin_in = bin;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin_in = 1'($urandom);
    lat = -1; hs_bad = 0;
    if (!if8.busy) hs_bad++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        lat = i;
        if (if8.busy) hs_bad++;
        break;
      end else if (!if8.busy) hs_bad++;
    end
    d = if8.diff; bo = if8.borrow_out;
    @(posedge clk); #1;
    if (if8.done) hs_bad++;
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic bin,
                        output logic [1:0] d, output logic bo, output int lat);
    @(negedge clk);
    if2.start = 1'b1; if2.a = a; if2.b = b; if2.bin_in = bin;
    @(posedge clk); #1;
    if2.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (if2.done) begin lat = i; break; end
    end
    d = if2.diff; bo = if2.borrow_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic bo; int lat, hs; int e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({if8.busy, if8.done, if8.diff, if8.borrow_out} !== 11'd0) begin
      n_bad++; $display("FAIL reset_outputs8: got busy=%0b done=%0b diff=%h bo=%0b, want all 0",
                        if8.busy, if8.done, if8.diff, if8.borrow_out);
    end
    n_cmp++;
    if ({if2.busy, if2.done, if2.diff, if2.borrow_out} !== 5'd0) begin
      n_bad++; $display("FAIL reset_outputs2: got busy=%0b done=%0b diff=%h bo=%0b, want all 0",
                        if2.busy, if2.done, if2.diff, if2.borrow_out);
    end
    @(negedge clk); rst = 1'b0;
    do_op8(8'h5A, 8'h3C, 1'b0, d, bo, lat, hs);
    e = ref_sub(8, 'h5A, 'h3C, 0);
    n_cmp++;
    if ({bo, d} !== 9'h01E || {bo, d} !== 9'(e)) begin
      n_bad++; $display("FAIL first_op: got diff=%h bo=%0b, want diff=1e bo=0", d, bo);
    end
    n_cmp++;
    if (lat !== 8 || hs !== 0) begin
      n_bad++; $display("FAIL first_op_timing: got latency=%0d handshake_errs=%0d, want 8 and 0", lat, hs);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] d; logic bo; int lat, hs;
    do_op8(8'h00, 8'h01, 1'b0, d, bo, lat, hs);
    n_cmp++;
    if ({bo, d} !== 9'h1FF || lat !== 8) begin
      n_bad++; $display("FAIL underflow_0_1: got diff=%h bo=%0b lat=%0d, want diff=ff bo=1 lat=8", d, bo, lat);
    end
    do_op8(8'h10, 8'h10, 1'b1, d, bo, lat, hs);
    n_cmp++;
    if ({bo, d} !== 9'h1FF || lat !== 8) begin
      n_bad++; $display("FAIL underflow_bin: got diff=%h bo=%0b lat=%0d, want diff=ff bo=1 lat=8", d, bo, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d; logic bin, bo; int lat, hs, e;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (k == 0) begin a = 8'hFF; b = 8'h00; bin = 1'b0; end
      if (k == 1) begin a = 8'h00; b = 8'hFF; bin = 1'b1; end
      do_op8(a, b, bin, d, bo, lat, hs);
      e = ref_sub(8, int'(a), int'(b), int'(bin));
      n_cmp++;
      if ({bo, d} !== 9'(e) || lat !== 8 || hs !== 0) begin
        n_bad++; $display("FAIL random_op %h-%h-%0b: got diff=%h bo=%0b lat=%0d hs=%0d, want diff=%h bo=%0b lat=8 hs=0",
                          a, b, bin, d, bo, lat, hs, e[7:0], e[8]);
      end
    end
  endtask

  task automatic test_exhaustive_w2();
    logic [1:0] d; logic bo; int lat, e; int bad;
    bad = 0;
    for (int v = 0; v < 32; v++) begin
      do_op2(2'(v >> 3), 2'(v >> 1), 1'(v), d, bo, lat);
      e = ref_sub(2, (v >> 3) & 3, (v >> 1) & 3, v & 1);
      n_cmp++;
      if ({bo, d} !== 3'(e) || lat !== 2) begin
        n_bad++; $display("FAIL w2_case_%0d: got diff=%h bo=%0b lat=%0d, want diff=%h bo=%0b lat=2",
                          v, d, bo, lat, e[1:0], e[2]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone; logic [7:0] d; logic bo; int lat, e;
    ndone = 0; d = '0; bo = 1'b0;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h01; if8.bin_in = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin if8.start = 1'b1; if8.a = 8'h00; if8.b = 8'hFF; if8.bin_in = 1'b0; end
      if (if8.done) begin ndone++; d = if8.diff; bo = if8.borrow_out; end
    end
    n_cmp++;
    if (ndone !== 1 || {bo, d} !== 9'h07F) begin
      n_bad++; $display("FAIL busy_start_ignored: got dones=%0d diff=%h bo=%0b, want 1 done diff=7f bo=0", ndone, d, bo);
    end
    n_cmp++;
    if (if8.busy !== 1'b0) begin
      n_bad++; $display("FAIL start_in_done: got busy=%0b after DONE edge, want 0", if8.busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (if8.busy !== 1'b1) begin
      n_bad++; $display("FAIL start_next_idle: got busy=%0b, want 1", if8.busy);
    end
    if8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin lat = i; break; end
    end
    e = ref_sub(8, 0, 'hFF, 0);
    n_cmp++;
    if (lat !== 8 || {if8.borrow_out, if8.diff} !== 9'(e)) begin
      n_bad++; $display("FAIL held_start_op: got lat=%0d diff=%h bo=%0b, want lat=8 diff=%h bo=%0b",
                        lat, if8.diff, if8.borrow_out, e[7:0], e[8]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int ndone; logic [7:0] d; logic bo; int lat, hs;
    ndone = 0;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'hF0; if8.b = 8'h0F; if8.bin_in = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({if8.busy, if8.done, if8.diff, if8.borrow_out} !== 11'd0) begin
      n_bad++; $display("FAIL reset_mid_run: got busy=%0b done=%0b diff=%h bo=%0b, want all 0",
                        if8.busy, if8.done, if8.diff, if8.borrow_out);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++; $display("FAIL no_done_after_reset: got %0d active cycles, want 0", ndone);
    end
    do_op8(8'h03, 8'h05, 1'b0, d, bo, lat, hs);
    n_cmp++;
    if ({bo, d} !== 9'h1FE || lat !== 8) begin
      n_bad++; $display("FAIL post_reset_op: got diff=%h bo=%0b lat=%0d, want diff=fe bo=1 lat=8", d, bo, lat);
    end
  endtask

  task automatic test_hold();
    int e;
    e = ref_sub(8, 3, 5, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin_in = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({if8.borrow_out, if8.diff} !== 9'(e) || if8.done !== 1'b0) begin
        n_bad++; $display("FAIL hold_cycle_%0d: got diff=%h bo=%0b done=%0b, want diff=%h bo=%0b done=0",
                          i, if8.diff, if8.borrow_out, if8.done, e[7:0], e[8]);
      end
    end
  endtask

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin_in = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.bin_in = 1'b0;
    test_reset();
    test_underflow();
    test_random();
    test_exhaustive_w2();
    test_start_while_busy();
    test_reset_mid_run();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
